// File: rtl/mem_copy_engine_if.sv
// Control and RAM-port signal bundle for mem_copy_engine.
// Ports: start/src_addr/dst_addr/length request the copy and busy/done report it;
//        mem_read/mem_write/mem_address/mem_wdata/mem_rdata form the RAM port.
interface mem_copy_engine_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [ADDR_WIDTH-1:0] dst_addr;
  logic [LEN_WIDTH-1:0]  length;
  logic                  busy;
  logic                  done;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Engine side.
  modport master (
    input  start, src_addr, dst_addr, length, mem_rdata,
    output busy, done, mem_read, mem_write, mem_address, mem_wdata
  );

  // Control path plus RAM side.
  modport slave (
    output start, src_addr, dst_addr, length, mem_rdata,
    input  busy, done, mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/mem_copy_engine.sv
// Block copy engine: copies length words from src_addr.. to dst_addr.. through a
// single-port RAM with one-cycle registered read latency, one word every 3 cycles.
// Ports: clk, reset (async, active-high), bus (master modport: request, status, RAM port).
module mem_copy_engine #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_copy_engine_if.master     bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] src_ptr, src_next;
  logic [ADDR_WIDTH-1:0] dst_ptr, dst_next;
  logic [LEN_WIDTH-1:0]  remaining, rem_next;
  logic [DATA_WIDTH-1:0] data_buf, buf_next;

  always_comb begin
    state_next = state;
    src_next   = src_ptr;
    dst_next   = dst_ptr;
    rem_next   = remaining;
    buf_next   = data_buf;
    case (state)
      IDLE: begin
        if (bus.start) begin
          src_next   = bus.src_addr;
          dst_next   = bus.dst_addr;
          rem_next   = bus.length;
          state_next = (bus.length == '0) ? DONE : READ;
        end
      end
      READ:    state_next = CAPTURE;
      CAPTURE: begin
        // RAM data_out is valid exactly one cycle after the READ strobe.
        buf_next   = bus.mem_rdata;
        state_next = WRITE;
      end
      WRITE: begin
        src_next   = src_ptr + ADDR_ONE;
        dst_next   = dst_ptr + ADDR_ONE;
        rem_next   = remaining - LEN_ONE;
        state_next = (rem_next != '0) ? READ : DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // All RAM-facing and status outputs are registered from the next-state
  // decode, so each is valid for the full cycle of the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      src_ptr         <= '0;
      dst_ptr         <= '0;
      remaining       <= '0;
      data_buf        <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.mem_read    <= 1'b0;
      bus.mem_write   <= 1'b0;
      bus.mem_address <= '0;
      bus.mem_wdata   <= '0;
    end else begin
      state           <= state_next;
      src_ptr         <= src_next;
      dst_ptr         <= dst_next;
      remaining       <= rem_next;
      data_buf        <= buf_next;
      bus.busy        <= (state_next == READ) || (state_next == CAPTURE) ||
                         (state_next == WRITE);
      bus.done        <= (state_next == DONE);
      bus.mem_read    <= (state_next == READ);
      bus.mem_write   <= (state_next == WRITE);
      bus.mem_address <= (state_next == READ)  ? src_next :
                         (state_next == WRITE) ? dst_next : '0;
      bus.mem_wdata   <= (state_next == WRITE) ? buf_next : '0;
    end
  end

endmodule
